// File: rtl/seq_acorr_driver.sv
// -----------------------------------------------------------------------------
// seq_acorr_driver
//
// Front-end sequencer for the sequence-search correlator. It latches one
// candidate binary sequence S and issues one cyclic shift per cycle to the
// correlator: corr_a = S and corr_b = S rotated right by k, for
// k = 1..SEQ_WIDTH-1. The signed 8-bit score returned for each shift is
// folded into two merit figures: the sidelobe energy (sum of P_k^2) and the
// peak sidelobe magnitude (max |P_k|).
//
// Ports
//   clk     in   1          clock
//   rst     in   1          synchronous reset, active-high
//   start   in   1          one-cycle request to evaluate seq_in (IDLE only)
//   seq_in  in   SEQ_WIDTH  candidate sequence, sampled on an accepted start
//   busy    out  1          evaluation in progress (through the done cycle)
//   done    out  1          one-cycle pulse; energy/peak valid from here
//   corr_a  out  SEQ_WIDTH  correlator input a (latched sequence S)
//   corr_b  out  SEQ_WIDTH  correlator input b (S rotated right by k)
//   corr_z  in   8          correlator score, signed two's complement
//   energy  out  32         sum over k of P_k^2
//   peak    out  8          max over k of |P_k|
// -----------------------------------------------------------------------------
module seq_acorr_driver #(
   parameter int SEQ_WIDTH    = 8,
   parameter int CORR_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SEQ_WIDTH-1:0]  seq_in,
   output logic                  busy,
   output logic                  done,
   output logic [SEQ_WIDTH-1:0]  corr_a,
   output logic [SEQ_WIDTH-1:0]  corr_b,
   input  logic signed [7:0]     corr_z,
   output logic [31:0]           energy,
   output logic [7:0]            peak
);

   localparam int KW = $clog2(SEQ_WIDTH);
   localparam logic [KW-1:0] K_LAST   = KW'(SEQ_WIDTH - 1);
   localparam logic [KW-1:0] CAP_LAST = KW'(SEQ_WIDTH - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   // |z| as an 8-bit unsigned value; -128 maps to 128 without overflow.
   function automatic logic [7:0] abs8(input logic signed [7:0] z);
      logic [7:0] u;
      u = z;
      return z[7] ? (~u + 8'd1) : u;
   endfunction

   // Square of a magnitude; at most 128*128 = 16384, so 16 bits suffice.
   function automatic logic [15:0] sq16(input logic [7:0] m);
      return {8'd0, m} * {8'd0, m};
   endfunction

   // Rotate right by one: result[i] = v[(i+1) mod N].
   function automatic logic [SEQ_WIDTH-1:0] rotr1(input logic [SEQ_WIDTH-1:0] v);
      return {v[0], v[SEQ_WIDTH-1:1]};
   endfunction

   logic [SEQ_WIDTH-1:0]    r_corr_a;
   logic [SEQ_WIDTH-1:0]    r_corr_b;
   logic [KW-1:0]           r_k;
   logic [KW-1:0]           r_ncap;
   logic [CORR_LATENCY-1:0] r_vld_p;
   logic [31:0]             r_energy;
   logic [7:0]              r_peak;

   logic                    w_issue_p0;
   logic                    w_cap;
   logic [7:0]              w_mag_p1;
   logic [15:0]             w_sq_p1;

   // ---- stage p0: shift k is on corr_a/corr_b this cycle ----
   assign w_issue_p0 = (r_state == S_ISSUE);

   // ---- stage p1: the score for the shift issued CORR_LATENCY cycles ago ----
   assign w_cap    = r_vld_p[CORR_LATENCY-1];
   assign w_mag_p1 = abs8(corr_z);
   assign w_sq_p1  = sq16(w_mag_p1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b1;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_k == K_LAST) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // r_ncap counts scores already taken; this capture is the last one.
            if (w_cap && (r_ncap == CAP_LAST)) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_corr_a <= '0;
         r_corr_b <= '0;
         r_k      <= '0;
         r_ncap   <= '0;
         r_vld_p  <= '0;
         r_energy <= '0;
         r_peak   <= '0;
      end else begin
         r_vld_p[0] <= w_issue_p0;
         for (int j = 1; j < CORR_LATENCY; j++) begin
            r_vld_p[j] <= r_vld_p[j-1];
         end

         if (w_cap) begin
            r_energy <= r_energy + {16'd0, w_sq_p1};
            if (w_mag_p1 > r_peak) begin
               r_peak <= w_mag_p1;
            end
            r_ncap <= r_ncap + KW'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  // corr_b is preloaded with shift 1 so it is presented in
                  // the very next cycle.
                  r_corr_a <= seq_in;
                  r_corr_b <= rotr1(seq_in);
                  r_k      <= KW'(1);
                  r_ncap   <= '0;
                  r_energy <= '0;
                  r_peak   <= '0;
               end
            end
            S_ISSUE: begin
               // Each further shift is one more rotation of the current
               // corr_b; after the last shift corr_a/corr_b simply hold.
               if (r_k != K_LAST) begin
                  r_corr_b <= rotr1(r_corr_b);
                  r_k      <= r_k + KW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign corr_a = r_corr_a;
   assign corr_b = r_corr_b;
   assign energy = r_energy;
   assign peak   = r_peak;

endmodule
